// File: rtl/twowire_dtm_serial.sv
// Two-wire debug serial link layer: connect/multidrop match, command framing with
// parity, write/read payload streaming with parity, turnaround and disconnect.
module twowire_dtm_serial #(
  parameter int unsigned W_CMD       = 4,
  parameter logic [11:0] CONNECT_KEY = 12'ha7c
) (
  input  logic             dck,
  input  logic             drst_n,
  input  logic             dio_i,
  output logic             dio_o,
  output logic             dio_oe,
  input  logic [3:0]       mdropaddr,
  output logic             connected,
  input  logic             disconnect_now,
  output logic [W_CMD-1:0] cmd,
  output logic             cmd_vld,
  input  logic             cmd_payload_end,
  output logic             serial_parity_err,
  output logic             serial_wdata,
  output logic             serial_wdata_vld,
  input  logic             serial_rdata,
  output logic             serial_rdata_rdy
);

  localparam int unsigned CNT_W = (W_CMD > 1) ? $clog2(W_CMD) : 1;
  localparam int unsigned WIN_W = 16;

  typedef enum logic [3:0] {
    S_DISCON,
    S_IDLE,
    S_CMD,
    S_CPAR,
    S_DISPATCH,
    S_WPAY,
    S_WPAR,
    S_RPAY,
    S_RPAR,
    S_RTURN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIN_W-1:0]   r_window;
  logic [WIN_W-1:0]   w_window_nxt;
  logic [WIN_W-1:0]   w_window_shift;
  logic [W_CMD-1:0]   r_cmd;
  logic [W_CMD-1:0]   w_cmd_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_acc;
  logic               w_acc_nxt;
  logic               r_perr;
  logic               w_perr_nxt;
  logic               w_is_write;

  assign w_window_shift = {r_window[WIN_W-2:0], dio_i};
  assign w_is_write     = (r_cmd == W_CMD'(3)) || (r_cmd == W_CMD'(5)) || (r_cmd == W_CMD'(9));

  assign cmd               = r_cmd;
  assign serial_parity_err = r_perr;

  // State and datapath registers
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      r_state  <= S_DISCON;
      r_window <= '0;
      r_cmd    <= '0;
      r_cnt    <= '0;
      r_acc    <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_window <= w_window_nxt;
      r_cmd    <= w_cmd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_perr   <= w_perr_nxt;
    end
  end

  // Next-state, datapath updates and state-decoded pin/handshake outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_window_nxt     = r_window;
    w_cmd_nxt        = r_cmd;
    w_cnt_nxt        = r_cnt;
    w_acc_nxt        = r_acc;
    w_perr_nxt       = 1'b0;
    connected        = (r_state != S_DISCON);
    cmd_vld          = 1'b0;
    dio_oe           = 1'b0;
    dio_o            = 1'b0;
    serial_wdata     = dio_i;
    serial_wdata_vld = 1'b0;
    serial_rdata_rdy = 1'b0;

    case (r_state)
      S_DISCON: begin
        w_window_nxt = w_window_shift;
        if ((w_window_shift[15:4] == CONNECT_KEY) && (w_window_shift[3:0] == mdropaddr)) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        if (!dio_i) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = CNT_W'(W_CMD - 1);
        end
      end

      S_CMD: begin
        w_cmd_nxt[r_cnt] = dio_i;
        if (r_cnt == '0) begin
          w_state_nxt = S_CPAR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      // Even parity over command bits plus the parity bit
      S_CPAR: begin
        if ((^r_cmd) ^ dio_i) begin
          w_perr_nxt   = 1'b1;
          w_state_nxt  = S_DISCON;
          w_window_nxt = '0;
        end else begin
          w_state_nxt = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        cmd_vld   = 1'b1;
        w_acc_nxt = 1'b0;
        if (disconnect_now) begin
          w_state_nxt  = S_DISCON;
          w_window_nxt = '0;
        end else if (w_is_write) begin
          w_state_nxt = S_WPAY;
        end else begin
          w_state_nxt = S_RPAY;
        end
      end

      S_WPAY: begin
        serial_wdata_vld = 1'b1;
        w_acc_nxt        = r_acc ^ dio_i;
        if (cmd_payload_end) begin
          w_state_nxt = S_WPAR;
        end
      end

      // Payload parity error keeps the link up
      S_WPAR: begin
        w_perr_nxt  = (dio_i != r_acc);
        w_state_nxt = S_IDLE;
      end

      S_RPAY: begin
        dio_oe           = 1'b1;
        dio_o            = serial_rdata;
        serial_rdata_rdy = 1'b1;
        w_acc_nxt        = r_acc ^ serial_rdata;
        if (cmd_payload_end) begin
          w_state_nxt = S_RPAR;
        end
      end

      S_RPAR: begin
        dio_oe      = 1'b1;
        dio_o       = r_acc;
        w_state_nxt = S_RTURN;
      end

      S_RTURN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt  = S_DISCON;
        w_window_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_twowire_dtm_serial.sv
// Randomized bench for twowire_dtm_serial: a host/core model drives the link at the
// transaction level and checks framing, payload, parity and connection behaviour.
module tb_twowire_dtm_serial;

  localparam int unsigned W_CMD = 4;
  localparam logic [11:0] KEY   = 12'ha7c;

  logic             dck = 1'b0;
  logic             drst_n;
  logic             dio_i;
  logic             dio_o;
  logic             dio_oe;
  logic [3:0]       mdropaddr;
  logic             connected;
  logic             disconnect_now;
  logic [W_CMD-1:0] cmd;
  logic             cmd_vld;
  logic             cmd_payload_end;
  logic             serial_parity_err;
  logic             serial_wdata;
  logic             serial_wdata_vld;
  logic             serial_rdata;
  logic             serial_rdata_rdy;

  int n_checks = 0;
  int n_pass   = 0;
  bit m_connected = 1'b0;

  twowire_dtm_serial #(.W_CMD(W_CMD), .CONNECT_KEY(KEY)) dut (
    .dck               (dck),
    .drst_n            (drst_n),
    .dio_i             (dio_i),
    .dio_o             (dio_o),
    .dio_oe            (dio_oe),
    .mdropaddr         (mdropaddr),
    .connected         (connected),
    .disconnect_now    (disconnect_now),
    .cmd               (cmd),
    .cmd_vld           (cmd_vld),
    .cmd_payload_end   (cmd_payload_end),
    .serial_parity_err (serial_parity_err),
    .serial_wdata      (serial_wdata),
    .serial_wdata_vld  (serial_wdata_vld),
    .serial_rdata      (serial_rdata),
    .serial_rdata_rdy  (serial_rdata_rdy)
  );

  always #5 dck = ~dck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Even parity of the low len bits of a word
  function automatic logic par_of(input logic [63:0] data, input int len);
    logic [63:0] mask;
    mask = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    return logic'($countones(data & mask) % 2);
  endfunction

  // One link cycle: drive inputs mid-low-phase, then let combinational outputs settle
  task automatic cyc(input logic b, input logic pend, input logic rd, input logic disc);
    @(negedge dck);
    dio_i           = b;
    cmd_payload_end = pend;
    serial_rdata    = rd;
    disconnect_now  = disc;
    #1;
  endtask

  function automatic logic rbit();
    return logic'($urandom % 2);
  endfunction

  task automatic connect(input logic [3:0] addr);
    logic [15:0] seq;
    logic        exp_conn;
    seq      = {KEY, addr};
    exp_conn = (addr == mdropaddr);
    repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      cyc(seq[i], 1'b0, 1'b0, 1'b0);
      if (i == 0) check("conn_before_last", 32'(connected), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("connect", 32'(connected), 32'(exp_conn));
    check("connect_oe", 32'(dio_oe), 32'd0);
    m_connected = exp_conn;
  endtask

  task automatic xact(input logic [3:0] c, input bit bad_cpar, input bit disc, input int len,
                      input logic [63:0] data, input bit bad_ppar, input int rst_at);
    logic b;
    logic p;
    bit   wr;
    wr = (c == 4'd3) || (c == 4'd5) || (c == 4'd9);
    p  = par_of(data, len);
    repeat ($urandom_range(0, 3)) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("idle_conn", 32'(connected), 32'd1);
      check("idle_oe", 32'(dio_oe), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("start_perr", 32'(serial_parity_err), 32'd0);
    check("start_vld", 32'(cmd_vld), 32'd0);
    for (int i = W_CMD - 1; i >= 0; i--) cyc(c[i], 1'b0, 1'b0, 1'b0);
    cyc(logic'((^c) ^ bad_cpar), 1'b0, 1'b0, 1'b0);
    check("cpar_novld", 32'(cmd_vld), 32'd0);
    if (bad_cpar) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("cpar_err", 32'(serial_parity_err), 32'd1);
      check("cpar_novld2", 32'(cmd_vld), 32'd0);
      check("cpar_conn", 32'(connected), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("cpar_pulse", 32'(serial_parity_err), 32'd0);
      m_connected = 1'b0;
      return;
    end
    cyc(rbit(), 1'b0, 1'b0, logic'(disc));
    check("disp_vld", 32'(cmd_vld), 32'd1);
    check("disp_cmd", 32'(cmd), 32'(c));
    check("disp_oe", 32'(dio_oe), 32'd0);
    check("disp_hs", 32'({serial_wdata_vld, serial_rdata_rdy}), 32'd0);
    if (disc) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("disc_conn", 32'(connected), 32'd0);
      check("disc_vld", 32'(cmd_vld), 32'd0);
      m_connected = 1'b0;
      return;
    end
    if (wr) begin
      for (int i = 0; i < len; i++) begin
        b = data[len-1-i];
        cyc(b, logic'(i == len - 1), 1'b0, 1'b0);
        check("w_vld", 32'(serial_wdata_vld), 32'd1);
        check("w_data", 32'(serial_wdata), 32'(b));
        check("w_oe", 32'(dio_oe), 32'd0);
      end
      cyc(logic'(p ^ bad_ppar), 1'b0, 1'b0, 1'b0);
      check("wpar_vld", 32'(serial_wdata_vld), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("wpar_err", 32'(serial_parity_err), 32'(bad_ppar));
      check("wpar_conn", 32'(connected), 32'd1);
    end else begin
      for (int i = 0; i < len; i++) begin
        b = data[len-1-i];
        cyc(rbit(), logic'(i == len - 1), b, 1'b0);
        check("r_oe", 32'(dio_oe), 32'd1);
        check("r_dio", 32'(dio_o), 32'(b));
        check("r_rdy", 32'(serial_rdata_rdy), 32'd1);
        if (i == rst_at) begin
          #1 drst_n = 1'b0;
          #1;
          check("rst_oe", 32'(dio_oe), 32'd0);
          check("rst_conn", 32'(connected), 32'd0);
          check("rst_vld", 32'(cmd_vld), 32'd0);
          @(negedge dck);
          drst_n      = 1'b1;
          m_connected = 1'b0;
          return;
        end
      end
      cyc(rbit(), 1'b0, 1'b0, 1'b0);
      check("rpar_oe", 32'(dio_oe), 32'd1);
      check("rpar_dio", 32'(dio_o), 32'(p));
      check("rpar_rdy", 32'(serial_rdata_rdy), 32'd0);
      cyc(rbit(), 1'b0, 1'b0, 1'b0);
      check("rturn_oe", 32'(dio_oe), 32'd0);
      check("rturn_conn", 32'(connected), 32'd1);
    end
  endtask

  initial begin
    logic [3:0] a;
    drst_n          = 1'b0;
    dio_i           = 1'b1;
    cmd_payload_end = 1'b0;
    serial_rdata    = 1'b0;
    disconnect_now  = 1'b0;
    mdropaddr       = 4'h5;
    #23;
    check("rst_connected", 32'(connected), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_vld", 32'(cmd_vld), 32'd0);
    check("rst_perr", 32'(serial_parity_err), 32'd0);
    check("rst_oe", 32'(dio_oe), 32'd0);
    check("rst_dio_o", 32'(dio_o), 32'd0);
    @(negedge dck);
    drst_n = 1'b1;

    connect(4'h6);
    connect(4'h5);
    xact(4'h1, 1'b0, 1'b0, 32, 64'h12345678, 1'b0, -1);
    xact(4'h3, 1'b0, 1'b0, 32, 64'h000000f0, 1'b0, -1);
    xact(4'h3, 1'b0, 1'b0, 32, 64'h000000f0, 1'b1, -1);
    xact(4'h1, 1'b1, 1'b0, 32, 64'h0, 1'b0, -1);
    connect(4'h5);
    xact(4'h0, 1'b0, 1'b1, 32, 64'h0, 1'b0, -1);
    connect(4'h5);
    xact(4'h1, 1'b0, 1'b0, 32, 64'h12345678, 1'b0, 10);

    for (int n = 0; n < 80; n++) begin
      if (!m_connected) begin
        mdropaddr = 4'($urandom);
        a = ($urandom % 5 == 0) ? (mdropaddr ^ 4'($urandom_range(1, 15))) : mdropaddr;
        connect(a);
      end else begin
        xact(4'($urandom), ($urandom % 8) == 0, ($urandom % 8) == 0,
             int'($urandom_range(1, 40)), {$urandom, $urandom}, ($urandom % 4) == 0,
             (($urandom % 10) == 0) ? 0 : -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
